axi_lite_a32_d32_slave_buf: RTL and testbench

// Slave-end bridge for the AXI-lite a32/d32 logic link.
// - Request path: unpacks AR/AW/W link words from the RX FIFOs and drives them as AXI-lite

---
 rtl/axi_lite_a32_d32_slave_buf.sv | 161 ++++++++++++++++
 tb/tb_axi_lite_a32_d32_slave_buf.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_a32_d32_slave_buf.sv
// Slave-end AXI-lite a32/d32 link bridge: link words <-> AXI-lite requests and responses.
// Latency: one cycle per channel. A word pushed at edge N is valid after N and can pop at N+1.
// Backpressure: registered ready per channel. It drops only when the slice is full and never follows out_ready combinationally.

// Generic registered FIFO slice used for every channel of the bridge
// Latency 1 cycle; output data always comes from the head register
// in_rdy is a flop computed from the next count, so no ready->ready comb path
module axi_lite_a32_d32_slave_buf_slice #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk_wr,
  input  logic         rst_wr,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_rdy_q, in_rdy_d;
  logic          push, pop;

  // Next-state: write at tail on push, advance head on pop, pointers wrap mod DEPTH
  always_comb begin
    push     = in_vld & in_rdy_q;
    pop      = (cnt_q != '0) & out_rdy;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    in_rdy_d = (cnt_d < DEPTH_C);
  end

  // State registers; reset empties the slice, clears storage and holds ready low
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = (cnt_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
endmodule

// Bridge top: three link->user slices (AR, AW, W) and two user->link slices (R, B)
// Latency 1 cycle on every channel; channels are independent and kept in FIFO order
// Each channel's ready drops only when its own slice is full
module axi_lite_a32_d32_slave_buf #(
  parameter int DEPTH = 2
) (
  input  logic        clk_wr,
  input  logic        rst_wr,
  input  logic        user_ar_lite_valid,
  input  logic [31:0] rxfifo_ar_lite_data,
  output logic        user_ar_lite_ready,
  input  logic        user_aw_lite_valid,
  input  logic [31:0] rxfifo_aw_lite_data,
  output logic        user_aw_lite_ready,
  input  logic        user_w_lite_valid,
  input  logic [35:0] rxfifo_w_lite_data,
  output logic        user_w_lite_ready,
  output logic        user_r_lite_valid,
  output logic [33:0] txfifo_r_lite_data,
  input  logic        user_r_lite_ready,
  output logic        user_b_lite_valid,
  output logic [1:0]  txfifo_b_lite_data,
  input  logic        user_b_lite_ready,
  output logic [31:0] user_araddr,
  output logic        user_arvalid,
  input  logic        user_arready,
  output logic [31:0] user_awaddr,
  output logic        user_awvalid,
  input  logic        user_awready,
  output logic [31:0] user_wdata,
  output logic [3:0]  user_wstrb,
  output logic        user_wvalid,
  input  logic        user_wready,
  input  logic [31:0] user_rdata,
  input  logic [1:0]  user_rresp,
  input  logic        user_rvalid,
  output logic        user_rready,
  input  logic [1:0]  user_bresp,
  input  logic        user_bvalid,
  output logic        user_bready,
  input  logic        m_gen2_mode
);
  logic [35:0] w_out_dat;
  logic        unused_gen2;

  // Link mode does not change any packing in this bridge
  assign unused_gen2 = m_gen2_mode;

  axi_lite_a32_d32_slave_buf_slice #(.W(32), .DEPTH(DEPTH)) u_ar (
    .clk_wr (clk_wr), .rst_wr (rst_wr),
    .in_vld (user_ar_lite_valid), .in_dat (rxfifo_ar_lite_data), .in_rdy (user_ar_lite_ready),
    .out_vld(user_arvalid), .out_dat(user_araddr), .out_rdy(user_arready)
  );

  axi_lite_a32_d32_slave_buf_slice #(.W(32), .DEPTH(DEPTH)) u_aw (
    .clk_wr (clk_wr), .rst_wr (rst_wr),
    .in_vld (user_aw_lite_valid), .in_dat (rxfifo_aw_lite_data), .in_rdy (user_aw_lite_ready),
    .out_vld(user_awvalid), .out_dat(user_awaddr), .out_rdy(user_awready)
  );

  // W link word: [31:0]=wdata, [35:32]=wstrb
  axi_lite_a32_d32_slave_buf_slice #(.W(36), .DEPTH(DEPTH)) u_w (
    .clk_wr (clk_wr), .rst_wr (rst_wr),
    .in_vld (user_w_lite_valid), .in_dat (rxfifo_w_lite_data), .in_rdy (user_w_lite_ready),
    .out_vld(user_wvalid), .out_dat(w_out_dat), .out_rdy(user_wready)
  );
  assign user_wdata = w_out_dat[31:0];
  assign user_wstrb = w_out_dat[35:32];

  // R link word: [31:0]=rdata, [33:32]=rresp
  axi_lite_a32_d32_slave_buf_slice #(.W(34), .DEPTH(DEPTH)) u_r (
    .clk_wr (clk_wr), .rst_wr (rst_wr),
    .in_vld (user_rvalid), .in_dat ({user_rresp, user_rdata}), .in_rdy (user_rready),
    .out_vld(user_r_lite_valid), .out_dat(txfifo_r_lite_data), .out_rdy(user_r_lite_ready)
  );

  axi_lite_a32_d32_slave_buf_slice #(.W(2), .DEPTH(DEPTH)) u_b (
    .clk_wr (clk_wr), .rst_wr (rst_wr),
    .in_vld (user_bvalid), .in_dat (user_bresp), .in_rdy (user_bready),
    .out_vld(user_b_lite_valid), .out_dat(txfifo_b_lite_data), .out_rdy(user_b_lite_ready)
  );
endmodule

// File: tb/tb_axi_lite_a32_d32_slave_buf.sv
// Directed bench for the slave-end AXI-lite bridge.
// Inputs change 1ns after the rising edge and outputs are sampled at that point as well.
// Expected values are hand-computed constants.
module tb_axi_lite_a32_d32_slave_buf;
  logic        clk_wr = 1'b0;
  logic        rst_wr;
  logic        user_ar_lite_valid;
  logic [31:0] rxfifo_ar_lite_data;
  logic        user_ar_lite_ready;
  logic        user_aw_lite_valid;
  logic [31:0] rxfifo_aw_lite_data;
  logic        user_aw_lite_ready;
  logic        user_w_lite_valid;
  logic [35:0] rxfifo_w_lite_data;
  logic        user_w_lite_ready;
  logic        user_r_lite_valid;
  logic [33:0] txfifo_r_lite_data;
  logic        user_r_lite_ready;
  logic        user_b_lite_valid;
  logic [1:0]  txfifo_b_lite_data;
  logic        user_b_lite_ready;
  logic [31:0] user_araddr;
  logic        user_arvalid;
  logic        user_arready;
  logic [31:0] user_awaddr;
  logic        user_awvalid;
  logic        user_awready;
  logic [31:0] user_wdata;
  logic [3:0]  user_wstrb;
  logic        user_wvalid;
  logic        user_wready;
  logic [31:0] user_rdata;
  logic [1:0]  user_rresp;
  logic        user_rvalid;
  logic        user_rready;
  logic [1:0]  user_bresp;
  logic        user_bvalid;
  logic        user_bready;
  logic        m_gen2_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk_wr = ~clk_wr;

  axi_lite_a32_d32_slave_buf #(.DEPTH(2)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr),
    .user_ar_lite_valid(user_ar_lite_valid), .rxfifo_ar_lite_data(rxfifo_ar_lite_data),
    .user_ar_lite_ready(user_ar_lite_ready),
    .user_aw_lite_valid(user_aw_lite_valid), .rxfifo_aw_lite_data(rxfifo_aw_lite_data),
    .user_aw_lite_ready(user_aw_lite_ready),
    .user_w_lite_valid(user_w_lite_valid), .rxfifo_w_lite_data(rxfifo_w_lite_data),
    .user_w_lite_ready(user_w_lite_ready),
    .user_r_lite_valid(user_r_lite_valid), .txfifo_r_lite_data(txfifo_r_lite_data),
    .user_r_lite_ready(user_r_lite_ready),
    .user_b_lite_valid(user_b_lite_valid), .txfifo_b_lite_data(txfifo_b_lite_data),
    .user_b_lite_ready(user_b_lite_ready),
    .user_araddr(user_araddr), .user_arvalid(user_arvalid), .user_arready(user_arready),
    .user_awaddr(user_awaddr), .user_awvalid(user_awvalid), .user_awready(user_awready),
    .user_wdata(user_wdata), .user_wstrb(user_wstrb), .user_wvalid(user_wvalid),
    .user_wready(user_wready),
    .user_rdata(user_rdata), .user_rresp(user_rresp), .user_rvalid(user_rvalid),
    .user_rready(user_rready),
    .user_bresp(user_bresp), .user_bvalid(user_bvalid), .user_bready(user_bready),
    .m_gen2_mode(m_gen2_mode)
  );

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    rst_wr = 1'b1;
    user_ar_lite_valid = 1'b1; rxfifo_ar_lite_data = 32'h1111_1111;
    user_aw_lite_valid = 1'b1; rxfifo_aw_lite_data = 32'h2222_2222;
    user_w_lite_valid  = 1'b1; rxfifo_w_lite_data  = 36'hF_3333_3333;
    user_rvalid = 1'b1; user_rdata = 32'h4444_4444; user_rresp = 2'b11;
    user_bvalid = 1'b1; user_bresp = 2'b11;
    user_arready = 1'b0; user_awready = 1'b0; user_wready = 1'b0;
    user_r_lite_ready = 1'b0; user_b_lite_ready = 1'b0;
    m_gen2_mode = 1'b0;
    repeat (3) tick();
    checks++;
    if ({user_arvalid, user_awvalid, user_wvalid, user_r_lite_valid, user_b_lite_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b expected 00000",
               {user_arvalid, user_awvalid, user_wvalid, user_r_lite_valid, user_b_lite_valid});
    end
    checks++;
    if ({user_ar_lite_ready, user_aw_lite_ready, user_w_lite_ready, user_rready, user_bready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_readies: got %b expected 00000",
               {user_ar_lite_ready, user_aw_lite_ready, user_w_lite_ready, user_rready, user_bready});
    end
    checks++;
    if ({user_araddr, user_awaddr, user_wdata, user_wstrb, txfifo_r_lite_data, txfifo_b_lite_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got ar=%h aw=%h w=%h/%h r=%h b=%h expected all 0",
               user_araddr, user_awaddr, user_wdata, user_wstrb, txfifo_r_lite_data, txfifo_b_lite_data);
    end
    rst_wr = 1'b0;
    user_ar_lite_valid = 1'b0; user_aw_lite_valid = 1'b0; user_w_lite_valid = 1'b0;
    user_rvalid = 1'b0; user_bvalid = 1'b0;
    tick();
    checks++;
    if ({user_ar_lite_ready, user_aw_lite_ready, user_w_lite_ready, user_rready, user_bready} !== 5'b11111) begin
      errors++;
      $display("FAIL release_readies: got %b expected 11111",
               {user_ar_lite_ready, user_aw_lite_ready, user_w_lite_ready, user_rready, user_bready});
    end
    checks++;
    if ({user_arvalid, user_awvalid, user_wvalid, user_r_lite_valid, user_b_lite_valid} !== 5'b0) begin
      errors++;
      $display("FAIL release_valids: got %b expected 00000",
               {user_arvalid, user_awvalid, user_wvalid, user_r_lite_valid, user_b_lite_valid});
    end
  endtask

  task automatic test_ar_single();
    user_arready = 1'b1;
    user_ar_lite_valid = 1'b1; rxfifo_ar_lite_data = 32'hDEAD_BEEF;
    tick();
    user_ar_lite_valid = 1'b0;
    checks++;
    if (user_arvalid !== 1'b1 || user_araddr !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ar_single: got vld=%b addr=%h expected vld=1 addr=deadbeef", user_arvalid, user_araddr);
    end
    tick();
    checks++;
    if (user_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL ar_one_cycle: got vld=%b expected 0", user_arvalid);
    end
  endtask

  task automatic test_packing();
    user_wready = 1'b0;
    user_w_lite_valid = 1'b1; rxfifo_w_lite_data = 36'hA_1234_5678;
    tick();
    user_w_lite_valid = 1'b0;
    checks++;
    if (user_wvalid !== 1'b1 || user_wdata !== 32'h1234_5678 || user_wstrb !== 4'hA) begin
      errors++;
      $display("FAIL w_pack: got vld=%b data=%h strb=%h expected 1 12345678 a", user_wvalid, user_wdata, user_wstrb);
    end
    user_wready = 1'b1;
    tick();
    checks++;
    if (user_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL w_pop: got vld=%b expected 0", user_wvalid);
    end
    user_r_lite_ready = 1'b0;
    user_rvalid = 1'b1; user_rdata = 32'hCAFE_F00D; user_rresp = 2'b10;
    tick();
    user_rvalid = 1'b0;
    checks++;
    if (user_r_lite_valid !== 1'b1 || txfifo_r_lite_data !== 34'h2_CAFE_F00D) begin
      errors++;
      $display("FAIL r_pack: got vld=%b data=%h expected 1 2cafef00d", user_r_lite_valid, txfifo_r_lite_data);
    end
    user_r_lite_ready = 1'b1;
    tick();
    checks++;
    if (user_r_lite_valid !== 1'b0) begin
      errors++;
      $display("FAIL r_pop: got vld=%b expected 0", user_r_lite_valid);
    end
  endtask

  task automatic test_backpressure();
    user_awready = 1'b0;
    user_aw_lite_valid = 1'b1; rxfifo_aw_lite_data = 32'd1;
    tick();
    checks++;
    if (user_aw_lite_ready !== 1'b1) begin
      errors++;
      $display("FAIL aw_ready_one: got %b expected 1", user_aw_lite_ready);
    end
    rxfifo_aw_lite_data = 32'd2;
    tick();
    rxfifo_aw_lite_data = 32'd3;
    checks++;
    if (user_aw_lite_ready !== 1'b0 || user_awvalid !== 1'b1 || user_awaddr !== 32'd1) begin
      errors++;
      $display("FAIL aw_full: got rdy=%b vld=%b addr=%h expected 0 1 1", user_aw_lite_ready, user_awvalid, user_awaddr);
    end
    tick();
    checks++;
    if (user_aw_lite_ready !== 1'b0 || user_awaddr !== 32'd1) begin
      errors++;
      $display("FAIL aw_hold: got rdy=%b addr=%h expected 0 1", user_aw_lite_ready, user_awaddr);
    end
    user_awready = 1'b1;
    tick();
    checks++;
    if (user_aw_lite_ready !== 1'b1 || user_awvalid !== 1'b1 || user_awaddr !== 32'd2) begin
      errors++;
      $display("FAIL aw_second: got rdy=%b vld=%b addr=%h expected 1 1 2", user_aw_lite_ready, user_awvalid, user_awaddr);
    end
    tick();
    user_aw_lite_valid = 1'b0;
    checks++;
    if (user_awvalid !== 1'b1 || user_awaddr !== 32'd3) begin
      errors++;
      $display("FAIL aw_third: got vld=%b addr=%h expected 1 3", user_awvalid, user_awaddr);
    end
    tick();
    checks++;
    if (user_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL aw_drain: got vld=%b expected 0", user_awvalid);
    end
  endtask

  task automatic test_streaming();
    logic [1:0] exp_b;
    user_b_lite_ready = 1'b1;
    user_bvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      exp_b = 2'(i);
      user_bresp = exp_b;
      tick();
      checks++;
      if (user_b_lite_valid !== 1'b1 || txfifo_b_lite_data !== exp_b || user_bready !== 1'b1) begin
        errors++;
        $display("FAIL b_stream[%0d]: got vld=%b data=%b rdy=%b expected 1 %b 1",
                 i, user_b_lite_valid, txfifo_b_lite_data, user_bready, exp_b);
      end
    end
    user_bvalid = 1'b0;
    tick();
    checks++;
    if (user_b_lite_valid !== 1'b0) begin
      errors++;
      $display("FAIL b_drain: got vld=%b expected 0", user_b_lite_valid);
    end
  endtask

  task automatic test_reset_mid();
    user_r_lite_ready = 1'b0;
    user_rvalid = 1'b1; user_rdata = 32'h0000_00A1; user_rresp = 2'b01;
    tick();
    user_rdata = 32'h0000_00A2;
    tick();
    user_rvalid = 1'b0;
    checks++;
    if (user_r_lite_valid !== 1'b1 || user_rready !== 1'b0 || txfifo_r_lite_data !== 34'h1_0000_00A1) begin
      errors++;
      $display("FAIL r_buffered: got vld=%b rdy=%b data=%h expected 1 0 1000000a1",
               user_r_lite_valid, user_rready, txfifo_r_lite_data);
    end
    rst_wr = 1'b1;
    tick();
    checks++;
    if (user_r_lite_valid !== 1'b0 || txfifo_r_lite_data !== 34'h0) begin
      errors++;
      $display("FAIL r_mid_reset: got vld=%b data=%h expected 0 0", user_r_lite_valid, txfifo_r_lite_data);
    end
    rst_wr = 1'b0;
    tick();
    checks++;
    if (user_r_lite_valid !== 1'b0 || user_rready !== 1'b1) begin
      errors++;
      $display("FAIL r_after_reset: got vld=%b rdy=%b expected 0 1", user_r_lite_valid, user_rready);
    end
    user_r_lite_ready = 1'b1;
    tick();
    checks++;
    if (user_r_lite_valid !== 1'b0) begin
      errors++;
      $display("FAIL r_no_stale: got vld=%b expected 0", user_r_lite_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ar_single();
    test_packing();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
